// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin, packet-locked arbiter driving a 4:1 WIDTH-bit mux onto one valid/ready channel.
// A grant is held until a last beat transfers or the granted lane idles for TIMEOUT cycles.
module mux_4_1_rr_arbiter #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_valid,
   input  logic [3:0]       in_last,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [3:0]       in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic [1:0]       sel,
   output logic             busy
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_sel;
   logic [1:0]       w_sel_nxt;
   logic [1:0]       r_rr_ptr;
   logic [1:0]       w_rr_ptr_nxt;
   logic [CW-1:0]    r_idle_cnt;
   logic [CW-1:0]    w_idle_cnt_nxt;
   logic             w_lane_valid;
   logic             w_lane_last;
   logic [1:0]       w_pick;
   logic [WIDTH-1:0] w_mux;

   // Scan downwards so the lane closest to ptr (in rotating order) is kept last.
   function automatic logic [1:0] f_rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic [1:0] res;
      res = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) res = idx;
      end
      return res;
   endfunction

   assign w_pick       = f_rr_pick(in_valid, r_rr_ptr);
   assign w_lane_valid = in_valid[r_sel];
   assign w_lane_last  = in_last[r_sel];

   // Only the selected lane reaches the output, so X on other lanes stays contained.
   always_comb begin
      w_mux = d0;
      case (r_sel)
         2'd0: w_mux = d0;
         2'd1: w_mux = d1;
         2'd2: w_mux = d2;
         2'd3: w_mux = d3;
         default: w_mux = d0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sel      <= 2'd0;
         r_rr_ptr   <= 2'd0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_idle_cnt <= w_idle_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_sel_nxt      = r_sel;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_idle_cnt_nxt = r_idle_cnt;
      case (r_state)
         IDLE: begin
            w_idle_cnt_nxt = '0;
            if (|in_valid) begin
               w_state_nxt = GRANT;
               w_sel_nxt   = w_pick;
            end
         end
         GRANT: begin
            if (w_lane_valid) begin
               w_idle_cnt_nxt = '0;
               if (out_ready && w_lane_last) begin
                  w_state_nxt  = IDLE;
                  w_rr_ptr_nxt = r_sel + 2'd1;
               end
            end else if (r_idle_cnt == CNT_MAX) begin
               w_state_nxt    = IDLE;
               w_rr_ptr_nxt   = r_sel + 2'd1;
               w_idle_cnt_nxt = '0;
            end else begin
               w_idle_cnt_nxt = r_idle_cnt + CW'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 4'b0000;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      if (r_state == GRANT) begin
         out_valid       = w_lane_valid;
         out_last        = w_lane_last;
         busy            = 1'b1;
         in_ready[r_sel] = out_ready;
      end
   end

   assign out_data = w_mux;
   assign sel      = r_sel;

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
- Round-robin arbiter that shares a 4-lane, WIDTH-bit 4:1 mux datapath between four requesters on a single valid/ready output channel.
- Grants are packet-locked: the granted lane owns the mux until it transfers a beat flagged last, or until an idle watchdog expires.
- The block generates the mux select itself, steers the data, and returns ready only to the granted lane.

Parameters:
- WIDTH, 4, data width of each lane and of the output.
- TIMEOUT, 8, consecutive cycles a granted lane may hold in_valid low before its grant is revoked (minimum 1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-lane valid; bit i belongs to lane i.
- in_last  input  4  per-lane end-of-packet flag, sampled with the lane's valid.
- d0, d1, d2, d3  input  WIDTH each  lane data.
- in_ready  output  4  per-lane ready; at most one bit set.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  output beat data.
- out_last  output  1  output end-of-packet flag.
- out_ready  input  1  downstream ready.
- sel  output  2  current mux select (granted lane index).
- busy  output  1  high while a grant is held.

Behaviour:
- Reset is asynchronous and active-low. Clock is clk, reset is rst_n. While rst_n is low:
  - state = IDLE, sel = 0, rr_ptr = 0, idle_cnt = 0.
  - out_valid = 0, in_ready = 0, busy = 0, out_last = 0.
  - out_data = d0, since sel = 0 in the mux path.
- FSM states: IDLE and GRANT.
- IDLE:
  - out_valid = 0, in_ready = 0.
  - If any in_valid bit is set, pick the first set lane scanning rr_ptr, rr_ptr+1, ... modulo 4.
  - Register that lane into sel and move to GRANT.
  - Arbitration costs exactly one bubble cycle. The first beat appears on the output the cycle after the request is seen.
- GRANT (combinational pass-through, no data register):
  - out_valid = in_valid[sel].
  - out_data = mux of d0..d3 by sel.
  - out_last = in_last[sel].
  - in_ready[sel] = out_ready; every other in_ready bit = 0.
  - busy = 1.
- Beat transfer occurs when out_valid and out_ready are both high.
- Release on last: a transfer with out_last = 1 moves to IDLE, sets rr_ptr = sel + 1 (2-bit wrap, 3 -> 0) and clears idle_cnt.
- Watchdog:
  - In GRANT, idle_cnt increments each cycle in_valid[sel] = 0 and clears whenever in_valid[sel] = 1.
  - When idle_cnt reaches TIMEOUT-1 with in_valid[sel] still 0, the block goes to IDLE next cycle with rr_ptr = sel + 1.
  - No beat is produced on a watchdog release.
- Back-to-back: a new grant never starts in the same cycle as a release. There is always one IDLE cycle between packets.
- Fairness: a requester continuously asserting valid is granted within at most 3 intervening packets.
- Lane order and stability:
  - Non-granted lanes may change valid, last and data freely without affecting the output.
  - sel is stable for the entire grant.
- Backpressure: out_ready = 0 with in_valid[sel] = 1 holds the beat and does not advance the watchdog.
- Reset mid-packet: the grant is dropped immediately, and the interrupted packet is not resumed after reset.
- X on a non-selected lane must not propagate to out_data.

Test Plan:
- Single lane: lane 2 sends 3 beats 'ha,'hb,'hc (last on 'hc), out_ready = 1 -> after a 1-cycle bubble:
  - sel = 2, out_data = 'ha,'hb,'hc on consecutive cycles, out_last on the third beat.
  - Then IDLE, rr_ptr = 3.
- Round-robin: all four lanes hold 1-beat packets (d0 = 7, d1 = 10, d2 = 3, d3 = 'hd) from reset -> grant order 0,1,2,3,0, outputs 7,10,3,'hd, with an IDLE cycle between grants.
- Backpressure: lane 1 granted, out_ready low for 5 cycles -> out_data is held, in_ready[1] = 0, no release. With TIMEOUT = 8 the watchdog does not fire.
- Watchdog: lane 0 granted, sends 1 non-last beat, then drops valid -> release exactly TIMEOUT cycles after valid drops, busy = 0, next grant goes to lane 1 if requesting.
- Isolation: lane 3 granted while d0 = 'x and in_valid[0] toggles -> out_data = d3 with no X, and in_ready[0] stays 0.
- Reset mid-packet: assert rst_n = 0 during beat 2 of a 4-beat lane-2 packet -> all outputs go to reset values asynchronously. After release, rr_ptr = 0, so lane 0 wins over lane 2 if both request.
